// File: rtl/inst_fetch_ctrl_if.sv
// Fetch-side bus between the instruction-fetch sequencer and its environment (ROM, decode, program control).
// INST_FETCH_CYCLE_COUNT_EN adds the cycle_count signal to the bus.
interface inst_fetch_ctrl_if #(
    parameter int unsigned A = 10,
    parameter int unsigned W = 9
);
    logic         start;
    logic         stall;
    logic         branch_en;
    logic [A-1:0] branch_target;
    logic [W-1:0] inst_in;
    logic [A-1:0] inst_address;
    logic [W-1:0] inst;
    logic         inst_valid;
    logic         done;
`ifdef INST_FETCH_CYCLE_COUNT_EN
    logic [15:0]  cycle_count;
`endif

    modport master (
        output start, stall, branch_en, branch_target, inst_in,
        input  inst_address, inst, inst_valid, done
`ifdef INST_FETCH_CYCLE_COUNT_EN
        , input cycle_count
`endif
    );

    modport slave (
        input  start, stall, branch_en, branch_target, inst_in,
        output inst_address, inst, inst_valid, done
`ifdef INST_FETCH_CYCLE_COUNT_EN
        , output cycle_count
`endif
    );
endinterface

// File: rtl/inst_fetch_ctrl.sv
// Instruction-fetch sequencer: owns the PC, latches ROM words into the IR, redirects on branches, stops on HALT.
// Optional RUN-cycle counter enabled by defining INST_FETCH_CYCLE_COUNT_EN.
module inst_fetch_ctrl #(
    parameter int unsigned    A          = 10,
    parameter int unsigned    W          = 9,
    parameter logic [A-1:0]   START_ADDR = {A{1'b0}},
    parameter logic [W-1:0]   HALT_WORD  = {W{1'b1}}
) (
    input  logic              clk,
    input  logic              reset,     // synchronous, active-low
    inst_fetch_ctrl_if.slave  bus
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [A-1:0] PC_ONE = {{(A-1){1'b0}}, 1'b1};

    state_t       state_r, state_s;
    logic [A-1:0] pc_r, pc_s;
    logic [W-1:0] inst_r, inst_s;
    logic         inst_valid_r, inst_valid_s;
    logic         done_r, done_s;
    logic [W-1:0] start_word_r, start_word_s;

    // Next-state and next-register values for the fetch sequencer
    always_comb begin
        state_s      = state_r;
        pc_s         = pc_r;
        inst_s       = inst_r;
        inst_valid_s = inst_valid_r;
        done_s       = done_r;
        start_word_s = start_word_r;
        case (state_r)
            IDLE: begin
                // PC sits on START_ADDR here, so inst_in is the first program word;
                // it is kept so a restart from DONE (PC elsewhere) can issue it too.
                start_word_s = bus.inst_in;
                if (bus.start) begin
                    state_s      = RUN;
                    pc_s         = START_ADDR + PC_ONE;
                    inst_s       = bus.inst_in;
                    inst_valid_s = 1'b1;
                    done_s       = 1'b0;
                end else begin
                    pc_s         = START_ADDR;
                end
            end
            RUN: begin
                if (bus.stall) begin
                    state_s = RUN;
                end else if (inst_valid_r && (inst_r == HALT_WORD)) begin
                    state_s      = DONE;
                    inst_s       = {W{1'b0}};
                    inst_valid_s = 1'b0;
                    done_s       = 1'b1;
                end else if (bus.branch_en) begin
                    pc_s         = bus.branch_target;
                    inst_s       = {W{1'b0}};
                    inst_valid_s = 1'b0;
                end else begin
                    pc_s         = pc_r + PC_ONE;
                    inst_s       = bus.inst_in;
                    inst_valid_s = 1'b1;
                end
            end
            DONE: begin
                if (bus.start) begin
                    state_s      = RUN;
                    pc_s         = START_ADDR + PC_ONE;
                    inst_s       = start_word_r;
                    inst_valid_s = 1'b1;
                    done_s       = 1'b0;
                end else begin
                    inst_s       = {W{1'b0}};
                    inst_valid_s = 1'b0;
                    done_s       = 1'b1;
                end
            end
            default: begin
                state_s      = IDLE;
                pc_s         = START_ADDR;
                inst_s       = {W{1'b0}};
                inst_valid_s = 1'b0;
                done_s       = 1'b0;
            end
        endcase
    end

    // Sequencer state registers with synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_r      <= IDLE;
            pc_r         <= START_ADDR;
            inst_r       <= {W{1'b0}};
            inst_valid_r <= 1'b0;
            done_r       <= 1'b0;
            start_word_r <= {W{1'b0}};
        end else begin
            state_r      <= state_s;
            pc_r         <= pc_s;
            inst_r       <= inst_s;
            inst_valid_r <= inst_valid_s;
            done_r       <= done_s;
            start_word_r <= start_word_s;
        end
    end

    assign bus.inst_address = pc_r;
    assign bus.inst         = inst_r;
    assign bus.inst_valid   = inst_valid_r;
    assign bus.done         = done_r;

`ifdef INST_FETCH_CYCLE_COUNT_EN
    logic [15:0] cycle_count_r, cycle_count_s;

    // RUN-cycle counter: saturating, cleared when a program start is accepted
    always_comb begin
        cycle_count_s = cycle_count_r;
        if (state_r == RUN) begin
            if (cycle_count_r != 16'hFFFF) begin
                cycle_count_s = cycle_count_r + 16'd1;
            end else begin
                cycle_count_s = cycle_count_r;
            end
        end else if (bus.start) begin
            cycle_count_s = 16'd0;
        end else begin
            cycle_count_s = cycle_count_r;
        end
    end

    // Cycle counter register
    always_ff @(posedge clk) begin
        if (!reset) begin
            cycle_count_r <= 16'd0;
        end else begin
            cycle_count_r <= cycle_count_s;
        end
    end

    assign bus.cycle_count = cycle_count_r;
`endif

endmodule
